// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO register pair with a multi-cycle radix-2 multiply / restoring divide sequencer.
// MTHI/MTLO write in one cycle; mult/div run DATA_W iterations plus a sign-fix cycle.
module hilo_muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              ReadHiLo,
    output logic              Busy,
    output logic              Stall,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              Done,
    output logic              DivByZero
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [2*DATA_W-1:0]   acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]     opb;      // multiplicand or divisor magnitude
    logic                  is_div, neg_q, neg_r, dz;

    logic                  idle_start, accept_md, wr_hi, wr_lo;
    logic                  signed_op, rs_neg, rt_neg, dz_in;
    logic [DATA_W-1:0]     rs_mag, rt_mag;
    logic [DATA_W:0]       mul_sum, div_sh;
    logic [DATA_W-1:0]     r_sub, r_new;
    logic                  div_ge;
    logic [2*DATA_W-1:0]   acc_step, prod_fix;
    logic [DATA_W-1:0]     q_fix, r_fix;

    assign idle_start = (state == IDLE) && Start;
    assign accept_md  = idle_start && !Op[2];
    assign wr_hi      = idle_start && (Op == 3'b100);
    assign wr_lo      = idle_start && (Op == 3'b101);

    // Even op codes are the signed variants
    assign signed_op  = !Op[0];
    assign rs_neg     = signed_op && RsData[DATA_W-1];
    assign rt_neg     = signed_op && RtData[DATA_W-1];
    assign rs_mag     = rs_neg ? -RsData : RsData;
    assign rt_mag     = rt_neg ? -RtData : RtData;
    assign dz_in      = Op[1] && (RtData == '0);

    assign Busy  = (state != IDLE);
    assign Stall = Busy && (Start || ReadHiLo);

    // One iteration of either algorithm
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opb : {DATA_W{1'b0}})};
        div_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        r_sub    = div_sh[DATA_W-1:0] - opb;
        r_new    = div_ge ? r_sub : div_sh[DATA_W-1:0];
        acc_step = is_div ? {r_new, acc[DATA_W-2:0], div_ge}
                          : {mul_sum, acc[DATA_W-1:1]};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        r_fix    = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_md) state_nxt = dz_in ? FIX : ITER;
            ITER: if (cnt == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            HI        <= '0;
            LO        <= '0;
            cnt       <= '0;
            acc       <= '0;
            opb       <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            if (wr_hi) HI <= RsData;
            if (wr_lo) LO <= RsData;
            case (state)
                IDLE: if (accept_md) begin
                    acc    <= {{DATA_W{1'b0}}, rs_mag};
                    opb    <= rt_mag;
                    is_div <= Op[1];
                    neg_q  <= rs_neg ^ rt_neg;
                    neg_r  <= rs_neg;
                    dz     <= dz_in;
                    cnt    <= '0;
                end
                ITER: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    Done      <= 1'b1;
                    DivByZero <= dz;
                    if (!dz) begin
                        if (is_div) begin
                            HI <= r_fix;
                            LO <= q_fix;
                        end else begin
                            HI <= prod_fix[2*DATA_W-1:DATA_W];
                            LO <= prod_fix[DATA_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: vector table of mult/div results plus
// hand-written sequences for divide-by-zero, stall behaviour and mid-flight reset.
module tb_hilo_muldiv_sequencer;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                           MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b111;

    logic         Clk = 1'b0;
    logic         Reset, Start, ReadHiLo;
    logic [2:0]   Op;
    logic [W-1:0] RsData, RtData;
    logic         Busy, Stall, Done, DivByZero;
    logic [W-1:0] HI, LO;

    int n_chk = 0;
    int n_fail = 0;

    hilo_muldiv_sequencer #(.DATA_W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .RsData(RsData), .RtData(RtData),
        .ReadHiLo(ReadHiLo), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO), .Done(Done),
        .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs, rt, hi, lo;
        int           busy;
        logic         dbz;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [W-1:0] v);
        @(negedge Clk);
        Start = 1'b1; Op = op; RsData = v;
        @(negedge Clk);
        Start = 1'b0; Op = NOP;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] rs,
                          input logic [W-1:0] rt, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int ebusy, input logic edbz);
        int  nb;
        bit  got;
        nb = 0; got = 0;
        @(negedge Clk);
        Start = 1'b1; Op = op; RsData = rs; RtData = rt;
        @(negedge Clk);
        Start = 1'b0; Op = NOP;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin got = 1; break; end
            if (Busy) nb++;
            @(negedge Clk);
        end
        check({name, " done_seen"}, 64'(got), 64'd1);
        check({name, " busy_cycles"}, 64'(nb), 64'(ebusy));
        check({name, " busy_at_done"}, 64'(Busy), 64'd0);
        check({name, " dbz"}, 64'(DivByZero), 64'(edbz));
        check({name, " HI"}, 64'(HI), 64'(ehi));
        check({name, " LO"}, 64'(LO), 64'(elo));
        @(negedge Clk);
        check({name, " done_pulse_len"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int bad, done_cnt;
        tbl[0] = '{MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0};
        tbl[1] = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33, 1'b0};
        tbl[2] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0};
        tbl[3] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        tbl[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0};
        tbl[5] = '{MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
        tbl[6] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0};
        tbl[7] = '{DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 33, 1'b0};
        tbl[8] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0};

        Reset = 1'b0; Start = 1'b0; Op = NOP; RsData = '0; RtData = '0; ReadHiLo = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("idle Stall", 64'(Stall), 64'd0);
        Reset = 1'b1; ReadHiLo = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   tbl[i].hi, tbl[i].lo, tbl[i].busy, tbl[i].dbz);

        // Divide by zero leaves preloaded HI/LO untouched
        write_hilo(MTHI, 32'h11);
        write_hilo(MTLO, 32'h22);
        check("mthi", 64'(HI), 64'h11);
        check("mtlo", 64'(LO), 64'h22);
        run_op("divu_by_zero", DIVU, 32'd100, 32'd0, 32'h11, 32'h22, 1, 1'b1);

        // Stall while busy; held MTLO lands after the mult completes
        @(negedge Clk);
        Start = 1'b1; Op = MULTU; RsData = 32'd3; RtData = 32'd5;
        @(negedge Clk);
        Op = MTLO; RsData = 32'hABCD; ReadHiLo = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 100 && !Done; i++) begin
            if (!Busy || !Stall) bad++;
            @(negedge Clk);
            #1;
        end
        check("stall_done_seen", 64'(Done), 64'd1);
        check("stall_while_busy_errs", 64'(bad), 64'd0);
        check("stall_on_done", 64'(Stall), 64'd0);
        check("stall_mult_LO", 64'(LO), 64'd15);
        check("stall_mult_HI", 64'(HI), 64'd0);
        @(negedge Clk);
        Start = 1'b0; Op = NOP; ReadHiLo = 1'b0;
        check("held_mtlo_LO", 64'(LO), 64'hABCD);
        check("held_mtlo_busy", 64'(Busy), 64'd0);

        // Reset mid-divide discards the operation
        @(negedge Clk);
        Start = 1'b1; Op = DIV; RsData = 32'd100; RtData = 32'd7;
        @(negedge Clk);
        Start = 1'b0; Op = NOP;
        repeat (10) @(negedge Clk);
        check("pre_reset_busy", 64'(Busy), 64'd1);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("midreset HI", 64'(HI), 64'd0);
        check("midreset LO", 64'(LO), 64'd0);
        check("midreset Busy", 64'(Busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) done_cnt++;
            @(negedge Clk);
        end
        check("midreset no_done", 64'(done_cnt), 64'd0);
        check("midreset LO_kept", 64'(LO), 64'd0);
        run_op("post_reset_multu", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide sequencer that owns the processor's HI/LO register pair, which drives the top-level ALUhi/ALUlo observation ports.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a radix-2 shift-add multiply or restoring divide over DATA_W iterations.
- Raises Stall to the hazard unit whenever a dependent HI/LO access, or a new mult/div op, arrives while the sequencer is busy.

Parameters:
- DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low; sampled on rising Clk edge.
- Start  in  1  EX stage presents a HI/LO-writing op this cycle.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- RsData  in  DATA_W  rs operand (multiplicand / dividend / MTHI-MTLO source).
- RtData  in  DATA_W  rt operand (multiplier / divisor).
- ReadHiLo  in  1  MFHI/MFLO in EX needs current HI/LO.
- Busy  out  1  sequencer running (ITER or FIX state).
- Stall  out  1  combinational: Busy & (Start | ReadHiLo).
- HI  out  DATA_W  HI register.
- LO  out  DATA_W  LO register.
- Done  out  1  one-cycle pulse after HI/LO update by mult/div.
- DivByZero  out  1  one-cycle pulse coincident with Done when divisor was 0.

Behaviour:
- Reset (Reset==0 at edge): state IDLE; HI=LO=0; Busy=Done=DivByZero=0; iteration counter=0. Aborts any op mid-flight; partial results discarded.
- States: IDLE, ITER, FIX.
- IDLE, Start=1, Op=MTHI/MTLO: HI (resp. LO) <= RsData on that edge; stay IDLE; no Done.
- IDLE, Start=1, Op=mult/div: accept edge. Latch operand magnitudes (signed ops: two's-complement abs; unsigned: raw). Latch result-sign flags: product/quotient sign = sign(Rs)^sign(Rt); remainder sign = sign(Rs). Go to ITER, counter=0.
- IDLE, Start=1, Op=11x: ignored.
- Divisor zero (DIV/DIVU with RtData==0): skip ITER, go straight to FIX.
  - FIX leaves HI/LO unchanged.
  - Done and DivByZero pulse next cycle.
- ITER: one shift-add (mult) or shift-compare-subtract (div) step per cycle. Counter increments; after DATA_W cycles (counter==DATA_W-1 at edge) go to FIX.
- FIX: apply sign correction.
  - MULT: negate 2*DATA_W product if sign flag set.
  - DIV: negate quotient/remainder per flags.
  - Write HI/LO on the FIX edge: mult HI=product[63:32], LO=product[31:0]; div LO=quotient, HI=remainder. Go to IDLE.
- Timing: accept at edge E0 -> Busy=1 cycles E0+1..E0+33 (32 ITER + 1 FIX) -> HI/LO valid and Done=1 in cycle after edge E0+33; Busy=0 then. Divide-by-zero: Busy one cycle, Done two cycles after accept.
- Busy=1: Start of any op (incl. MTHI/MTLO) is ignored and Stall=1; the pipeline holds EX so the op re-presents after completion. ReadHiLo=1 also gives Stall=1.
- Done cycle: Busy=0, so Stall=0 and the held op is accepted or the read proceeds with the new HI/LO.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no flag). Product never overflows 2*DATA_W.
- HI/LO hold value in all cycles not written.

Test Plan:
- MULT Rs=0xFFFFFFFF, Rt=0x00000002 accepted at E0 -> Busy E0+1..E0+33; Done one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE; DIVU Rs=100, Rt=7 -> LO=14, HI=2.
- DIV Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU Rs=100, Rt=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> HI/LO unchanged; Done=DivByZero=1 same cycle; Busy exactly one cycle.
- ReadHiLo=1 and Start(MTLO) held during a MULT -> Stall=1 every Busy cycle, 0 on Done cycle; MTLO then overwrites LO next edge.
- Reset=0 during ITER cycle 10 of a DIV -> next cycle HI=LO=0, Busy=0, no Done pulse; fresh MULTU 3*5 -> LO=15, HI=0.
